// File: rtl/max7219_receiver.sv
// max7219_receiver: behavioural receiver for a daisy chain of NUM_DEV MAX7219
// LED drivers. Serial words are shifted in while LOAD is low. On the rising
// edge of LOAD, every device word is decoded into its register file.
// Optional feature: define MAX7219_RECEIVER_SYNC_EN to put two-flop
// synchronisers on the SPI inputs. The edge-to-action latency is then 3 cycles
// instead of 1.
module max7219_receiver #(
  parameter int NUM_DEV = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_SPI_Stb,
  input  logic                   i_SPI_Clk,
  input  logic                   i_SPI_Din,
  output logic                   o_SPI_Dout,
  output logic [NUM_DEV*64-1:0]  o_Digits,
  output logic [NUM_DEV*8-1:0]   o_DecodeMode,
  output logic [NUM_DEV*4-1:0]   o_Intensity,
  output logic [NUM_DEV*3-1:0]   o_ScanLimit,
  output logic [NUM_DEV-1:0]     o_Shutdown,
  output logic [NUM_DEV-1:0]     o_DisplayTest,
  output logic                   o_Load,
  output logic                   o_FrameErr
);

  localparam int SR_W  = 16 * NUM_DEV;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SR_W);

  logic s_stb;
  logic s_clk;
  logic s_din;

`ifdef MAX7219_RECEIVER_SYNC_EN
  logic [1:0] stb_sync;
  logic [1:0] clk_sync;
  logic [1:0] din_sync;

  // Two-flop synchronisers. LOAD starts at its idle (high) level so that
  // leaving reset is not mistaken for the end of a frame.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      stb_sync <= 2'b11;
      clk_sync <= 2'b00;
      din_sync <= 2'b00;
    end else begin
      stb_sync <= {stb_sync[0], i_SPI_Stb};
      clk_sync <= {clk_sync[0], i_SPI_Clk};
      din_sync <= {din_sync[0], i_SPI_Din};
    end
  end

  assign s_stb = stb_sync[1];
  assign s_clk = clk_sync[1];
  assign s_din = din_sync[1];
`else
  assign s_stb = i_SPI_Stb;
  assign s_clk = i_SPI_Clk;
  assign s_din = i_SPI_Din;
`endif

  logic            prev_stb;
  logic            prev_clk;
  logic            stb_rise;
  logic            stb_fall;
  logic            do_shift;
  logic [SR_W-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;

  // Previous sampled levels for edge detection. LOAD idles high.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      prev_stb <= 1'b1;
      prev_clk <= 1'b0;
    end else begin
      prev_stb <= s_stb;
      prev_clk <= s_clk;
    end
  end

  assign stb_rise = s_stb & ~prev_stb;
  assign stb_fall = ~s_stb & prev_stb;
  // Serial clock edges only count while LOAD is low, which also discards a
  // clock rise coincident with the LOAD rise.
  assign do_shift = s_clk & ~prev_clk & ~s_stb;

  // Shift register and saturating bit counter. A LOAD fall restarts the count.
  // A shift in that same cycle is still counted.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      if (do_shift)
        shift_reg <= {shift_reg[SR_W-2:0], s_din};
      if (stb_fall)
        bit_cnt <= do_shift ? CNT_W'(1) : '0;
      else if (do_shift && bit_cnt != CNT_FULL)
        bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign o_SPI_Dout = shift_reg[SR_W-1];

  // Address and data fields of each device word. Device 0 is the word nearest
  // the input. Bits [15:12] carry no meaning.
  logic [3:0] word_addr [NUM_DEV];
  logic [7:0] word_data [NUM_DEV];

  for (genvar k = 0; k < NUM_DEV; k++) begin : g_word
    assign word_addr[k] = shift_reg[16*k+8 +: 4];
    assign word_data[k] = shift_reg[16*k +: 8];
  end

  // On a LOAD rise, either decode a complete frame into the registers or flag
  // a short frame. The registers and the pulse update on the same edge.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Digits      <= '0;
      o_DecodeMode  <= '0;
      o_Intensity   <= '0;
      o_ScanLimit   <= '0;
      o_Shutdown    <= '1;
      o_DisplayTest <= '0;
      o_Load        <= 1'b0;
      o_FrameErr    <= 1'b0;
    end else begin
      o_Load     <= stb_rise && (bit_cnt == CNT_FULL);
      o_FrameErr <= stb_rise && (bit_cnt != CNT_FULL);
      if (stb_rise && bit_cnt == CNT_FULL) begin
        for (int k = 0; k < NUM_DEV; k++) begin
          case (word_addr[k])
            4'h9: o_DecodeMode[8*k +: 8] <= word_data[k];
            4'hA: o_Intensity[4*k +: 4]  <= word_data[k][3:0];
            4'hB: o_ScanLimit[3*k +: 3]  <= word_data[k][2:0];
            4'hC: o_Shutdown[k]          <= ~word_data[k][0];
            4'hF: o_DisplayTest[k]       <= word_data[k][0];
            default: begin
              for (int d = 0; d < 8; d++) begin
                if (word_addr[k] == 4'(d + 1))
                  o_Digits[64*k + 8*d +: 8] <= word_data[k];
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_max7219_receiver.sv
// tb_max7219_receiver: self-checking bench for max7219_receiver (NUM_DEV=2).
// The bench honours MAX7219_RECEIVER_SYNC_EN for the expected latency.
module tb_max7219_receiver;

  localparam int NUM_DEV = 2;
`ifdef MAX7219_RECEIVER_SYNC_EN
  localparam int LATENCY = 3;
`else
  localparam int LATENCY = 1;
`endif

  logic         i_Clk = 1'b0;
  logic         i_Rst_n;
  logic         i_SPI_Stb;
  logic         i_SPI_Clk;
  logic         i_SPI_Din;
  logic         o_SPI_Dout;
  logic [127:0] o_Digits;
  logic [15:0]  o_DecodeMode;
  logic [7:0]   o_Intensity;
  logic [5:0]   o_ScanLimit;
  logic [1:0]   o_Shutdown;
  logic [1:0]   o_DisplayTest;
  logic         o_Load;
  logic         o_FrameErr;

  max7219_receiver #(.NUM_DEV(NUM_DEV)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_SPI_Stb(i_SPI_Stb),
    .i_SPI_Clk(i_SPI_Clk), .i_SPI_Din(i_SPI_Din), .o_SPI_Dout(o_SPI_Dout),
    .o_Digits(o_Digits), .o_DecodeMode(o_DecodeMode), .o_Intensity(o_Intensity),
    .o_ScanLimit(o_ScanLimit), .o_Shutdown(o_Shutdown),
    .o_DisplayTest(o_DisplayTest), .o_Load(o_Load), .o_FrameErr(o_FrameErr)
  );

  always #5 i_Clk = ~i_Clk;

  int errors = 0;
  int checks = 0;

  // Reference register file of each device plus the chain contents.
  logic [7:0]  m_digit  [NUM_DEV][8];
  logic [7:0]  m_decode [NUM_DEV];
  logic [3:0]  m_intens [NUM_DEV];
  logic [2:0]  m_scan   [NUM_DEV];
  logic        m_shut   [NUM_DEV];
  logic        m_test   [NUM_DEV];
  logic [31:0] m_chain;
  logic [63:0] dout_trace;

  typedef struct {
    string       name;
    logic [63:0] bits;
    int          n;
    int          exp_load;
    int          exp_err;
  } vec_t;

  function automatic void modelReset();
    for (int k = 0; k < NUM_DEV; k++) begin
      for (int d = 0; d < 8; d++) m_digit[k][d] = 8'h00;
      m_decode[k] = 8'h00;
      m_intens[k] = 4'h0;
      m_scan[k]   = 3'h0;
      m_shut[k]   = 1'b1;
      m_test[k]   = 1'b0;
    end
    m_chain = 32'h0;
  endfunction

  // A frame of n bits sent MSB first. The chain keeps the last 32 bits.
  // Only a frame of at least 32 bits updates the devices.
  function automatic void modelFrame(input logic [63:0] bits, input int n);
    logic [15:0] w;
    int a;
    if (n >= 32) m_chain = bits[31:0];
    else if (n > 0) m_chain = (m_chain << n) | (bits[31:0] & ((32'h1 << n) - 32'h1));
    if (n >= 32) begin
      for (int k = 0; k < NUM_DEV; k++) begin
        w = bits[16*k +: 16];
        a = int'(w[11:8]);
        if (a >= 1 && a <= 8) m_digit[k][a-1] = w[7:0];
        else if (a == 9)  m_decode[k] = w[7:0];
        else if (a == 10) m_intens[k] = w[3:0];
        else if (a == 11) m_scan[k]   = w[2:0];
        else if (a == 12) m_shut[k]   = ~w[0];
        else if (a == 15) m_test[k]   = w[0];
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every output against the model while the bus is idle.
  task automatic checkAll(input string tag);
    logic [127:0] ed;
    logic [15:0]  edm;
    logic [7:0]   ei;
    logic [5:0]   es;
    logic [1:0]   esh;
    logic [1:0]   edt;
    for (int k = 0; k < NUM_DEV; k++) begin
      for (int d = 0; d < 8; d++) ed[64*k+8*d +: 8] = m_digit[k][d];
      edm[8*k +: 8] = m_decode[k];
      ei[4*k +: 4]  = m_intens[k];
      es[3*k +: 3]  = m_scan[k];
      esh[k]        = m_shut[k];
      edt[k]        = m_test[k];
    end
    checkOutput({tag, " digits"},    o_Digits, ed);
    checkOutput({tag, " decode"},    128'(o_DecodeMode), 128'(edm));
    checkOutput({tag, " intensity"}, 128'(o_Intensity), 128'(ei));
    checkOutput({tag, " scanlimit"}, 128'(o_ScanLimit), 128'(es));
    checkOutput({tag, " shutdown"},  128'(o_Shutdown), 128'(esh));
    checkOutput({tag, " disptest"},  128'(o_DisplayTest), 128'(edt));
    checkOutput({tag, " dout"},      128'(o_SPI_Dout), 128'(m_chain[31]));
    checkOutput({tag, " load idle"}, 128'(o_Load), 128'(0));
    checkOutput({tag, " ferr idle"}, 128'(o_FrameErr), 128'(0));
  endtask

  // Shift n bits MSB first; record o_SPI_Dout after each shift.
  task automatic shiftBits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      i_SPI_Din = bits[i];
      @(negedge i_Clk);
      i_SPI_Clk = 1'b1;
      repeat (2) @(negedge i_Clk);
      i_SPI_Clk = 1'b0;
      repeat (2) @(negedge i_Clk);
      dout_trace = {dout_trace[62:0], o_SPI_Dout};
    end
  endtask

  // Watch a bounded window after a LOAD rise and check the pulses and latency.
  task automatic watchLatch(input string tag, input int exp_load, input int exp_err);
    int loads, errs, first;
    loads = 0; errs = 0; first = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge i_Clk);
      if (o_Load) loads++;
      if (o_FrameErr) errs++;
      if ((o_Load || o_FrameErr) && first < 0) first = c;
    end
    checkOutput({tag, " load pulses"}, 128'(loads), 128'(exp_load));
    checkOutput({tag, " ferr pulses"}, 128'(errs), 128'(exp_err));
    checkOutput({tag, " latency"}, 128'(first), 128'(LATENCY));
  endtask

  // One complete transaction: LOAD low, shift, LOAD high, compare with model.
  task automatic applyStimulus(input string tag, input logic [63:0] bits, input int n,
                               input int exp_load, input int exp_err);
    i_SPI_Stb = 1'b0;
    repeat (3) @(negedge i_Clk);
    shiftBits(bits, n);
    repeat (2) @(negedge i_Clk);
    i_SPI_Stb = 1'b1;
    watchLatch(tag, exp_load, exp_err);
    modelFrame(bits, n);
    checkAll(tag);
  endtask

  vec_t vecs [6];

  initial begin
    logic [63:0] rbits;
    int rn;
    int r;

    vecs[0] = '{"ignored addrs", 64'h0000_0000_0D55_0E66, 32, 1, 0};
    vecs[1] = '{"decode+test",   64'h0000_0000_19FF_0F01, 32, 1, 0};
    vecs[2] = '{"shutdown",      64'h0000_0000_0C01_0C00, 32, 1, 0};
    vecs[3] = '{"empty frame",   64'h0,                   0,  0, 1};
    vecs[4] = '{"31 bits",       64'h0000_0000_7A03_0A05, 31, 0, 1};
    vecs[5] = '{"digits 8/1",    64'h0000_0000_0855_01AA, 32, 1, 0};

    dout_trace = '0;
    i_Rst_n = 1'b0; i_SPI_Stb = 1'b1; i_SPI_Clk = 1'b0; i_SPI_Din = 1'b0;
    modelReset();
    repeat (3) @(negedge i_Clk);
    checkAll("in reset");
    i_Rst_n = 1'b1;
    repeat (6) @(negedge i_Clk);
    checkAll("after reset");
    checkOutput("reset shutdown", 128'(o_Shutdown), 128'(2'b11));

    applyStimulus("intensity/shutdown", 64'h0A03_0C01, 32, 1, 0);
    checkOutput("dev1 intensity", 128'(o_Intensity[7:4]), 128'(4'd3));
    checkOutput("dev0 shutdown", 128'(o_Shutdown[0]), 128'(1'b0));

    applyStimulus("digits", 64'h0181_0800, 32, 1, 0);
    checkOutput("dev1 digit0", 128'(o_Digits[71:64]), 128'(8'h81));
    checkOutput("dev0 digit7", 128'(o_Digits[63:56]), 128'(8'h00));

    applyStimulus("17 bits", 64'h1_2345, 17, 0, 1);

    applyStimulus("48 bits", 64'hF001_0B07_0000, 48, 1, 0);
    checkOutput("dev1 scanlimit", 128'(o_ScanLimit[5:3]), 128'(3'd7));
    checkOutput("dout word", 128'(dout_trace[16:1]), 128'(16'hF001));

    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i].name, vecs[i].bits, vecs[i].n, vecs[i].exp_load, vecs[i].exp_err);

    // A serial clock rise coincident with the LOAD rise must not shift.
    rbits = {32'h0, $urandom()};
    i_SPI_Stb = 1'b0;
    repeat (3) @(negedge i_Clk);
    shiftBits(rbits, 32);
    repeat (2) @(negedge i_Clk);
    i_SPI_Din = ~rbits[0];
    @(negedge i_Clk);
    i_SPI_Stb = 1'b1;
    i_SPI_Clk = 1'b1;
    watchLatch("coincident clk", 1, 0);
    i_SPI_Clk = 1'b0;
    modelFrame(rbits, 32);
    repeat (2) @(negedge i_Clk);
    checkAll("coincident clk");

    // Reset in the middle of a frame discards the partial frame.
    i_SPI_Stb = 1'b0;
    repeat (3) @(negedge i_Clk);
    shiftBits(64'hABCDE, 20);
    i_Rst_n = 1'b0;
    i_SPI_Stb = 1'b1;
    modelReset();
    repeat (2) @(negedge i_Clk);
    checkAll("mid-frame reset");
    i_Rst_n = 1'b1;
    repeat (4) @(negedge i_Clk);
    applyStimulus("post-reset frame", 64'h0A0C_0B05, 32, 1, 0);

    // Randomized frames of assorted lengths against the model.
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) rn = 32;
      else if (r < 8) rn = 48;
      else rn = int'($urandom_range(0, 31));
      rbits = {$urandom(), $urandom()};
      if (rn < 64) rbits = rbits & ((64'h1 << rn) - 64'h1);
      applyStimulus("random", rbits, rn, (rn >= 32) ? 1 : 0, (rn >= 32) ? 0 : 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
